// File: rtl/multibit_mcp_rx.sv
`default_nettype none
// ============================================================================
//  Module   : multibit_mcp_rx
//  Desc     : Destination-domain endpoint of the toggle/ack multi-cycle-path
//             multibit CDC. Synchronizes the sender toggle, captures the
//             quasi-static data bus on each toggle edge, presents it on a
//             valid/ready interface and returns a toggle-encoded ack once
//             the word has been consumed.
//  Revision : 1.0 - initial release
// ============================================================================
module multibit_mcp_rx #(
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 2,   // legal range 2..4
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   a_toggle,
    input  logic [DATA_WIDTH-1:0]  a_data,
    output logic                   b_ack_toggle,
    output logic                   bvalid,
    output logic [DATA_WIDTH-1:0]  bdata,
    input  logic                   bready,
    output logic                   overflow,
    output logic [COUNT_WIDTH-1:0] rx_count,
    output logic [COUNT_WIDTH-1:0] drop_count
);

    // bvalid is the state itself: EMPTY means no pending word
    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] c_count_max = '1;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [SYNC_STAGES-1:0]  r_sync;
    logic                    r_ref;
    logic                    w_edge;
    logic                    w_accept;
    logic                    w_load;
    logic                    w_drop;
    logic [DATA_WIDTH-1:0]   r_bdata;
    logic                    r_ack;
    logic                    r_overflow;
    logic [COUNT_WIDTH-1:0]  r_rx_count;
    logic [COUNT_WIDTH-1:0]  r_drop_count;

    // Only the synchronized toggle is used for control; a_data is sampled
    // directly on the edge cycle because the sender holds it stable.
    assign w_edge = r_sync[SYNC_STAGES-1] ^ r_ref;

    // Toggle synchronizer chain and edge reference flop
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_ref  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_toggle};
            r_ref  <= r_sync[SYNC_STAGES-1];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle action decode
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_load      = 1'b0;
        w_drop      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_edge) begin
                    w_load      = 1'b1;
                    w_state_nxt = FULL;
                end
            end
            FULL: begin
                if (bready) begin
                    // Accept; a same-cycle arrival reloads and stays FULL
                    w_accept = 1'b1;
                    if (w_edge) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = EMPTY;
                    end
                end else if (w_edge) begin
                    // New word while the old one is still pending: drop it
                    w_drop = 1'b1;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
    end

    // Holding register, ack toggle, sticky overflow and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bdata      <= '0;
            r_ack        <= 1'b0;
            r_overflow   <= 1'b0;
            r_rx_count   <= '0;
            r_drop_count <= '0;
        end else begin
            if (w_load) begin
                r_bdata <= a_data;
            end
            if (w_accept) begin
                r_ack      <= ~r_ack;
                r_rx_count <= r_rx_count + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != c_count_max) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    assign bvalid       = (r_state == FULL);
    assign bdata        = r_bdata;
    assign b_ack_toggle = r_ack;
    assign overflow     = r_overflow;
    assign rx_count     = r_rx_count;
    assign drop_count   = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_multibit_mcp_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multibit_mcp_rx
//  Desc     : Directed self-checking bench for multibit_mcp_rx with a data
//             scoreboard popped on every accepted word.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multibit_mcp_rx;

    localparam int DW = 32;
    localparam int SS = 2;
    localparam int CW = 16;

    logic          clk;
    logic          reset;
    logic          a_toggle;
    logic [DW-1:0] a_data;
    logic          b_ack_toggle;
    logic          bvalid;
    logic [DW-1:0] bdata;
    logic          bready;
    logic          overflow;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] drop_count;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] sb_q[$];

    multibit_mcp_rx #(
        .DATA_WIDTH (DW),
        .SYNC_STAGES(SS),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .a_toggle    (a_toggle),
        .a_data      (a_data),
        .b_ack_toggle(b_ack_toggle),
        .bvalid      (bvalid),
        .bdata       (bdata),
        .bready      (bready),
        .overflow    (overflow),
        .rx_count    (rx_count),
        .drop_count  (drop_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d, input bit expect_rx);
        a_data   = d;
        a_toggle = ~a_toggle;
        if (expect_rx) sb_q.push_back(d);
    endtask

    task automatic wait_ack_change(input logic prev, input string tag);
        int n;
        n = 0;
        while (b_ack_toggle === prev && n < 20) begin
            step();
            n++;
        end
        check(tag, (n < 20), 1);
    endtask

    // Scoreboard: an accept happens at the next edge whenever bvalid&&bready
    // is seen here (inputs only change just after rising edges)
    initial begin
        logic [DW-1:0] exp_w;
        forever begin
            @(negedge clk);
            if (!reset && bvalid && bready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_word", {32'h0, bdata}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("sb_data", bdata, exp_w);
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        a_toggle = 1'b0;
        a_data   = '0;
        bready   = 1'b0;
        repeat (2) step();
        check("rst_bvalid", bvalid, 0);
        check("rst_bdata", bdata, 0);
        check("rst_ack", b_ack_toggle, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rx", rx_count, 0);
        check("rst_drop", drop_count, 0);
        reset = 1'b0;
        step();

        // Single word: latency SS+1 edges, one-cycle valid with bready=1
        send(32'hDEADBEEF, 1);
        bready = 1'b1;
        for (int i = 1; i <= SS; i++) begin
            step();
            check("lat_not_yet", bvalid, 0);
        end
        step();
        check("lat_bvalid", bvalid, 1);
        check("lat_bdata", bdata, 32'hDEADBEEF);
        step();
        check("single_bvalid_fall", bvalid, 0);
        check("single_ack", b_ack_toggle, 1);
        check("single_rx", rx_count, 1);

        // Backpressure: bdata and ack stable while bready is low
        bready = 1'b0;
        send(32'hCAFEF00D, 1);
        repeat (SS + 1) step();
        check("bp_bvalid", bvalid, 1);
        a_data = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("bp_bdata_stable", bdata, 32'hCAFEF00D);
            check("bp_ack_stable", b_ack_toggle, 1);
        end
        bready = 1'b1;
        step();
        check("bp_bvalid_fall", bvalid, 0);
        check("bp_ack", b_ack_toggle, 0);
        check("bp_rx", rx_count, 2);

        // Back-to-back: sender waits for each ack edge
        for (int i = 1; i <= 3; i++) begin
            logic prev;
            prev = b_ack_toggle;
            send(DW'(i), 1);
            wait_ack_change(prev, "b2b_ack_timeout");
        end
        step();
        check("b2b_ack", b_ack_toggle, 1);
        check("b2b_rx", rx_count, 5);
        check("b2b_overflow", overflow, 0);
        check("b2b_bvalid", bvalid, 0);

        // Simultaneous accept and arrival
        bready = 1'b0;
        send(32'h100, 1);
        repeat (SS + 1) step();
        check("sim_first_valid", bvalid, 1);
        send(32'h200, 1);
        repeat (SS) step();
        bready = 1'b1;
        step();
        check("sim_bvalid_held", bvalid, 1);
        check("sim_bdata_new", bdata, 32'h200);
        check("sim_ack", b_ack_toggle, 0);
        check("sim_rx", rx_count, 6);
        check("sim_overflow", overflow, 0);
        check("sim_drop", drop_count, 0);
        step();
        check("sim_bvalid_fall", bvalid, 0);
        check("sim_ack2", b_ack_toggle, 1);
        check("sim_rx2", rx_count, 7);

        // Overflow: second edge while pending and bready low is dropped
        bready = 1'b0;
        send(32'h77, 1);
        repeat (SS + 1) step();
        check("ovf_first_valid", bvalid, 1);
        send(32'h55, 0);
        repeat (SS + 2) step();
        check("ovf_flag", overflow, 1);
        check("ovf_drop", drop_count, 1);
        check("ovf_bdata_old", bdata, 32'h77);
        check("ovf_bvalid", bvalid, 1);
        check("ovf_ack_held", b_ack_toggle, 1);
        bready = 1'b1;
        step();
        check("ovf_bvalid_fall", bvalid, 0);
        check("ovf_ack", b_ack_toggle, 0);
        repeat (4) step();
        check("ovf_ack_single", b_ack_toggle, 0);
        check("ovf_still_empty", bvalid, 0);
        check("ovf_rx", rx_count, 8);
        check("ovf_sticky", overflow, 1);

        // Reset mid-operation: FULL with another edge in the sync chain
        bready = 1'b0;
        send(32'h300, 0);
        repeat (SS + 1) step();
        check("mid_full", bvalid, 1);
        send(32'h400, 0);
        step();
        reset    = 1'b1;
        a_toggle = 1'b0;   // sender is reset alongside
        sb_q.delete();
        step();
        check("mid_rst_bvalid", bvalid, 0);
        check("mid_rst_bdata", bdata, 0);
        check("mid_rst_ack", b_ack_toggle, 0);
        check("mid_rst_overflow", overflow, 0);
        check("mid_rst_rx", rx_count, 0);
        check("mid_rst_drop", drop_count, 0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid_no_stale", bvalid, 0);
        end
        send(32'hABCD, 1);
        bready = 1'b1;
        repeat (SS + 1) step();
        check("fresh_bvalid", bvalid, 1);
        check("fresh_bdata", bdata, 32'hABCD);
        step();
        check("fresh_bvalid_fall", bvalid, 0);
        check("fresh_ack", b_ack_toggle, 1);
        check("fresh_rx", rx_count, 1);
        repeat (2) step();
        check("sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
